ysyx_22040386_trap_redirect_ctrl: RTL and testbench
===================================================

# ysyx_22040386_trap_redirect_ctrl

Sequencer for all control-flow redirects leaving the execute stage of the ysyx_22040386 core: taken branches/jumps, `ecall`, `mret` and the machine timer interrupt. It prioritises simultaneous requests and stalls the pipeline while it works. For traps and returns it drives the multi-cycle CSR update through the single CSR write port. It then hands exactly one redirect PC to the fetch stage over a valid/ready handshake.

## Interface
Parameters:
- XLEN, 64, datapath width
- MCAUSE_TIMER, 64'h8000_0000_0000_0007, cause code for machine timer interrupt
- MCAUSE_ECALL, 64'd11, cause code for ecall from M-mode

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- commit_valid  in  1  execute-stage instruction and all request inputs valid this cycle
- commit_pc  in  XLEN  PC of that instruction
- br_taken  in  1  normal branch/jal/jalr taken (branch-judge result, traps excluded)
- br_target  in  XLEN  branch/jump target
- ecall, mret, timer_irq  in  1 each  trap/return requests; timer_irq is level
- csr_mtvec, csr_mepc, csr_mstatus  in  XLEN  current CSR read values
- csr_wen  out  1  CSR write strobe
- csr_waddr  out  12  CSR address (0x341 mepc, 0x342 mcause, 0x300 mstatus)
- csr_wdata  out  XLEN  CSR write data
- stall  out  1  freeze IF/ID/EX
- redirect_valid  out  1  redirect_pc is valid
- redirect_pc  out  XLEN  new fetch PC
- redirect_ready  in  1  fetch accepts the redirect

## Operation
- States: IDLE, WR_MEPC, WR_MCAUSE, WR_MSTATUS, REDIRECT.
- Acceptance happens only in IDLE with commit_valid=1. The winning request is chosen by priority:
  - timer_irq with csr_mstatus[3] (MIE)=1
  - ecall
  - mret
  - br_taken
- A timer_irq with MIE=0 is ignored, and the next request in priority order is taken.
- On accept, latch the following and ignore later input changes until the sequence ends:
  - kind: timer, ecall, mret or branch
  - commit_pc
  - mstatus snapshot
  - target: trap → {csr_mtvec[63:2],2'b00}; mret → csr_mepc; branch → br_target
- Timer/ecall path: IDLE→WR_MEPC→WR_MCAUSE→WR_MSTATUS→REDIRECT.
  - WR_MEPC writes the latched commit_pc. For a timer interrupt this instruction has not executed.
  - WR_MCAUSE writes MCAUSE_TIMER or MCAUSE_ECALL.
  - WR_MSTATUS writes the snapshot with bit7 (MPIE) set to the old MIE, bit3 (MIE)=0 and bits[12:11] (MPP)=2'b11.
- mret path: IDLE→WR_MSTATUS→REDIRECT. The mstatus write is the snapshot with MIE set to the old MPIE, MPIE=1 and MPP=2'b11.
- Branch path: IDLE→REDIRECT with no CSR write.
- REDIRECT: hold redirect_valid=1 with redirect_pc constant until redirect_ready=1, then return to IDLE.
- csr_wen=1 only in the WR_* states, exactly one write per state. csr_waddr/csr_wdata are 0 when csr_wen=0.
- stall = (state≠IDLE) | (IDLE & an accepted request). This term is combinational, so the requesting instruction never advances the pipeline.
- No request is accepted in any non-IDLE state, and requests present then are not queued. The pipeline is stalled, so the same instruction re-presents its requests afterwards.

## Timing
- Reset (asynchronous, immediate): state=IDLE. csr_wen=0, csr_waddr=0, csr_wdata=0, redirect_valid=0, redirect_pc=0, stall=0. Latched registers are cleared.
- Reset mid-sequence aborts the sequence with no further CSR writes. Any CSR write already issued stands.
- All outputs except stall are registered from state.
- Latency from accept edge T, with redirect_ready=1:
  - trap: writes in cycles T+1, T+2, T+3; redirect_valid in T+4; IDLE in T+5
  - mret: write in T+1; redirect in T+2
  - branch: redirect in T+1
- redirect_ready low extends REDIRECT indefinitely, and stall stays 1 throughout.
- redirect_ready while redirect_valid=0 is ignored.
- A request is acceptable again in the first IDLE cycle after REDIRECT completes; there are no dead cycles.
- Simultaneous requests: only the highest-priority one is serviced. For example, ecall+br_taken yields the trap only, and br_target is discarded.

## Test plan
- Reset then commit_valid=1, br_taken=1, br_target=0x8000_0100, redirect_ready=1:
  - redirect_valid=1 with pc 0x8000_0100 in cycle T+1
  - stall=1 in T and T+1, 0 in T+2
  - csr_wen never 1
- ecall at commit_pc=0x8000_0040, mtvec=0x8000_1001, mstatus=0x8:
  - writes (0x341, 0x8000_0040), (0x342, 11), (0x300, 0x1880)
  - redirect to 0x8000_1000 in T+4
- timer_irq=1, mstatus=0x8, ecall=1, br_taken=1 in the same cycle:
  - mcause write is 0x8000_0000_0000_0007
  - the ecall and branch are dropped
- timer_irq=1, mstatus=0x0, br_taken=1: the branch redirect only, with no CSR writes.
- mret with mepc=0x8000_0044, mstatus=0x1880:
  - single write (0x300, 0x1888)
  - redirect to 0x8000_0044 in T+2
- Trap with redirect_ready held low for 3 cycles, then rst_n pulsed low mid-WR_MCAUSE on a second trap:
  - first case: redirect_valid/pc stable and stall=1 through the wait
  - second case: all outputs 0 immediately, no mstatus write follows

Source files
------------

// File: rtl/ysyx_22040386_trap_redirect_ctrl.sv
// Redirect sequencer for the execute stage: prioritises branch/ecall/mret/timer
// requests, drives the trap CSR update sequence and hands one PC to fetch.
module ysyx_22040386_trap_redirect_ctrl #(
  parameter int unsigned      XLEN         = 64,
  parameter logic [XLEN-1:0]  MCAUSE_TIMER = 64'h8000_0000_0000_0007,
  parameter logic [XLEN-1:0]  MCAUSE_ECALL = 64'd11
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            commit_valid,
  input  logic [XLEN-1:0] commit_pc,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            ecall,
  input  logic            mret,
  input  logic            timer_irq,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_mepc,
  input  logic [XLEN-1:0] csr_mstatus,
  output logic            csr_wen,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            stall,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready
);

  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MSTATUS = 12'h300;

  typedef enum logic [2:0] {
    IDLE, WR_MEPC, WR_MCAUSE, WR_MSTATUS, REDIRECT
  } state_t;

  typedef enum logic [1:0] {
    K_TIMER, K_ECALL, K_MRET, K_BRANCH
  } kind_t;

  state_t          state_q, state_d;
  kind_t           kind_q, req_kind;
  logic [XLEN-1:0] snap_q, target_q, req_target;
  logic            timer_hit, accept;

  logic            wen_d, rv_d;
  logic [11:0]     waddr_d;
  logic [XLEN-1:0] wdata_d, rpc_d;

  // Low mtvec bits are the mode field; only direct mode is supported.
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^csr_mtvec[1:0];

  function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r        = s;
    r[7]     = s[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r        = s;
    r[3]     = s[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Request arbitration; a masked timer interrupt falls through to the next request.
  always_comb begin
    timer_hit  = timer_irq & csr_mstatus[3];
    accept     = (state_q == IDLE) & commit_valid & (timer_hit | ecall | mret | br_taken);
    req_kind   = K_BRANCH;
    req_target = br_target;
    if (timer_hit) begin
      req_kind   = K_TIMER;
      req_target = {csr_mtvec[XLEN-1:2], 2'b00};
    end else if (ecall) begin
      req_kind   = K_ECALL;
      req_target = {csr_mtvec[XLEN-1:2], 2'b00};
    end else if (mret) begin
      req_kind   = K_MRET;
      req_target = csr_mepc;
    end
  end

  assign stall = accept | (state_q != IDLE);

  // Next state plus the registered output values for that state.
  always_comb begin
    state_d = state_q;
    wen_d   = 1'b0;
    waddr_d = '0;
    wdata_d = '0;
    rv_d    = 1'b0;
    rpc_d   = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (req_kind)
            K_TIMER, K_ECALL: begin
              state_d = WR_MEPC;
              wen_d   = 1'b1;
              waddr_d = ADDR_MEPC;
              wdata_d = commit_pc;
            end
            K_MRET: begin
              state_d = WR_MSTATUS;
              wen_d   = 1'b1;
              waddr_d = ADDR_MSTATUS;
              wdata_d = mret_mstatus(csr_mstatus);
            end
            default: begin
              state_d = REDIRECT;
              rv_d    = 1'b1;
              rpc_d   = br_target;
            end
          endcase
        end
      end
      WR_MEPC: begin
        state_d = WR_MCAUSE;
        wen_d   = 1'b1;
        waddr_d = ADDR_MCAUSE;
        wdata_d = (kind_q == K_TIMER) ? MCAUSE_TIMER : MCAUSE_ECALL;
      end
      WR_MCAUSE: begin
        state_d = WR_MSTATUS;
        wen_d   = 1'b1;
        waddr_d = ADDR_MSTATUS;
        wdata_d = trap_mstatus(snap_q);
      end
      WR_MSTATUS: begin
        state_d = REDIRECT;
        rv_d    = 1'b1;
        rpc_d   = target_q;
      end
      REDIRECT: begin
        if (redirect_ready) begin
          state_d = IDLE;
        end else begin
          rv_d  = 1'b1;
          rpc_d = target_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      kind_q         <= K_TIMER;
      snap_q         <= '0;
      target_q       <= '0;
      csr_wen        <= 1'b0;
      csr_waddr      <= '0;
      csr_wdata      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      state_q        <= state_d;
      csr_wen        <= wen_d;
      csr_waddr      <= waddr_d;
      csr_wdata      <= wdata_d;
      redirect_valid <= rv_d;
      redirect_pc    <= rpc_d;
      if (accept) begin
        kind_q   <= req_kind;
        snap_q   <= csr_mstatus;
        target_q <= req_target;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22040386_trap_redirect_ctrl.sv
// Bench for the redirect sequencer: directed table, reset corner cases and
// randomized transactions checked against a rule-level reference model.
module tb_ysyx_22040386_trap_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        commit_valid, br_taken, ecall, mret, timer_irq, redirect_ready;
  logic [63:0] commit_pc, br_target, csr_mtvec, csr_mepc, csr_mstatus;
  logic        csr_wen, stall, redirect_valid;
  logic [11:0] csr_waddr;
  logic [63:0] csr_wdata, redirect_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_22040386_trap_redirect_ctrl dut (
    .clk(clk), .rst_n(rst_n), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .br_taken(br_taken), .br_target(br_target), .ecall(ecall), .mret(mret),
    .timer_irq(timer_irq), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .csr_mstatus(csr_mstatus), .csr_wen(csr_wen), .csr_waddr(csr_waddr),
    .csr_wdata(csr_wdata), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
  );

  typedef struct packed {
    logic             acc;
    logic [1:0]       nwr;
    logic [2:0][11:0] wa;
    logic [2:0][63:0] wd;
    logic [63:0]      tgt;
  } exp_t;

  typedef struct packed {
    logic        cv, tmr, ec, mr, br;
    logic [63:0] pc, tgt, mtvec, mepc, ms;
    logic [1:0]  delay;
    exp_t        e;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_wen"},   64'(csr_wen), 64'd0);
    chk({tag, "_waddr"}, 64'(csr_waddr), 64'd0);
    chk({tag, "_wdata"}, csr_wdata, 64'd0);
    chk({tag, "_rv"},    64'(redirect_valid), 64'd0);
    chk({tag, "_rpc"},   redirect_pc, 64'd0);
  endtask

  task automatic clear_inputs();
    commit_valid = 0; commit_pc = '0; br_taken = 0; br_target = '0;
    ecall = 0; mret = 0; timer_irq = 0; csr_mtvec = '0; csr_mepc = '0;
    csr_mstatus = '0; redirect_ready = 0;
  endtask

  task automatic junk();
    commit_valid = 1'($urandom); commit_pc = {$urandom, $urandom};
    br_taken = 1'($urandom); br_target = {$urandom, $urandom};
    ecall = 1'($urandom); mret = 1'($urandom); timer_irq = 1'($urandom);
    csr_mtvec = {$urandom, $urandom}; csr_mepc = {$urandom, $urandom};
    csr_mstatus = {$urandom, $urandom}; redirect_ready = 1'($urandom);
  endtask

  // Reference model: priority rules and privileged-spec mstatus bit algebra.
  function automatic exp_t model(input vec_t v);
    exp_t e;
    logic tm;
    e  = '0;
    tm = v.tmr && v.ms[3];
    e.acc = v.cv && (tm || v.ec || v.mr || v.br);
    if (!e.acc) return e;
    if (tm || v.ec) begin
      e.nwr = 3;
      e.wa[0] = 12'h341; e.wd[0] = v.pc;
      e.wa[1] = 12'h342; e.wd[1] = tm ? 64'h8000_0000_0000_0007 : 64'd11;
      e.wa[2] = 12'h300;
      e.wd[2] = (v.ms & ~64'h1888) | 64'h1800 | (64'(v.ms[3]) << 7);
      e.tgt   = v.mtvec & ~64'h3;
    end else if (v.mr) begin
      e.nwr = 1;
      e.wa[0] = 12'h300;
      e.wd[0] = (v.ms & ~64'h1888) | 64'h1880 | (64'(v.ms[7]) << 3);
      e.tgt   = v.mepc;
    end else begin
      e.tgt = v.tgt;
    end
    return e;
  endfunction

  function automatic vec_t mkv(input logic cv, tmr, ec, mr, br,
                               input logic [63:0] pc, tgt, mtvec, mepc, ms,
                               input logic [1:0] delay);
    vec_t v;
    v = '0;
    v.cv = cv; v.tmr = tmr; v.ec = ec; v.mr = mr; v.br = br;
    v.pc = pc; v.tgt = tgt; v.mtvec = mtvec; v.mepc = mepc; v.ms = ms;
    v.delay = delay;
    return v;
  endfunction

  function automatic exp_t mke(input logic acc, input logic [1:0] nwr,
                               input logic [11:0] a0, input logic [63:0] d0,
                               input logic [11:0] a1, input logic [63:0] d1,
                               input logic [11:0] a2, input logic [63:0] d2,
                               input logic [63:0] tgt);
    exp_t e;
    e = '0;
    e.acc = acc; e.nwr = nwr; e.tgt = tgt;
    e.wa[0] = a0; e.wd[0] = d0; e.wa[1] = a1; e.wd[1] = d1; e.wa[2] = a2; e.wd[2] = d2;
    return e;
  endfunction

  // One transaction: present in an IDLE cycle, then follow the expected sequence
  // while the inputs are scrambled to show the latched values are used.
  task automatic run(input vec_t v, input string tag);
    @(negedge clk);
    commit_valid = v.cv; timer_irq = v.tmr; ecall = v.ec; mret = v.mr; br_taken = v.br;
    commit_pc = v.pc; br_target = v.tgt; csr_mtvec = v.mtvec; csr_mepc = v.mepc;
    csr_mstatus = v.ms; redirect_ready = 1'($urandom);
    #1;
    chk({tag, "_stall_T"}, 64'(stall), 64'(v.e.acc));
    chk_quiet({tag, "_idle"});
    if (!v.e.acc) return;
    for (int k = 0; k < int'(v.e.nwr); k++) begin
      @(negedge clk);
      junk();
      #1;
      chk({tag, "_wen"},   64'(csr_wen), 64'd1);
      chk({tag, "_waddr"}, 64'(csr_waddr), 64'(v.e.wa[k]));
      chk({tag, "_wdata"}, csr_wdata, v.e.wd[k]);
      chk({tag, "_wr_rv"}, 64'(redirect_valid), 64'd0);
      chk({tag, "_wr_stall"}, 64'(stall), 64'd1);
    end
    for (int d = 0; d <= int'(v.delay); d++) begin
      @(negedge clk);
      junk();
      redirect_ready = (d == int'(v.delay));
      #1;
      chk({tag, "_rv"},    64'(redirect_valid), 64'd1);
      chk({tag, "_rpc"},   redirect_pc, v.e.tgt);
      chk({tag, "_rd_wen"}, 64'(csr_wen), 64'd0);
      chk({tag, "_rd_waddr"}, 64'(csr_waddr), 64'd0);
      chk({tag, "_rd_stall"}, 64'(stall), 64'd1);
    end
  endtask

  vec_t tbl[11];
  vec_t rv;

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    #3;
    chk_quiet("reset");
    chk("reset_stall", 64'(stall), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    tbl[0]  = mkv(1,0,0,0,1, 64'h8000_0000, 64'h8000_0100, 64'h0, 64'h0, 64'h0, 0);
    tbl[0].e = mke(1, 0, 0,0, 0,0, 0,0, 64'h8000_0100);
    tbl[1]  = mkv(1,0,1,0,0, 64'h8000_0040, 64'h0, 64'h8000_1001, 64'h0, 64'h8, 0);
    tbl[1].e = mke(1, 3, 12'h341,64'h8000_0040, 12'h342,64'd11, 12'h300,64'h1880, 64'h8000_1000);
    tbl[2]  = mkv(1,1,1,0,1, 64'h8000_0080, 64'h8000_0300, 64'h8000_1001, 64'h0, 64'h8, 0);
    tbl[2].e = mke(1, 3, 12'h341,64'h8000_0080, 12'h342,64'h8000_0000_0000_0007,
                   12'h300,64'h1880, 64'h8000_1000);
    tbl[3]  = mkv(1,1,0,0,1, 64'h8000_0090, 64'h8000_0200, 64'h8000_1001, 64'h0, 64'h0, 0);
    tbl[3].e = mke(1, 0, 0,0, 0,0, 0,0, 64'h8000_0200);
    tbl[4]  = mkv(1,0,0,1,0, 64'h8000_00a0, 64'h0, 64'h0, 64'h8000_0044, 64'h1880, 0);
    tbl[4].e = mke(1, 1, 12'h300,64'h1888, 0,0, 0,0, 64'h8000_0044);
    tbl[5]  = mkv(1,0,1,0,0, 64'h8000_0050, 64'h0, 64'h8000_2000, 64'h0, 64'h0, 3);
    tbl[5].e = mke(1, 3, 12'h341,64'h8000_0050, 12'h342,64'd11, 12'h300,64'h1800, 64'h8000_2000);
    tbl[6]  = mkv(1,0,0,1,1, 64'h8000_00b0, 64'h999, 64'h0, 64'h1234, 64'h0, 1);
    tbl[6].e = mke(1, 1, 12'h300,64'h1880, 0,0, 0,0, 64'h1234);
    tbl[7]  = mkv(0,0,0,0,1, 64'h8000_00c0, 64'h8000_0400, 64'h0, 64'h0, 64'h8, 0);
    tbl[7].e = mke(0, 0, 0,0, 0,0, 0,0, 64'h0);
    tbl[8]  = mkv(1,1,0,0,0, 64'h8000_00d0, 64'h0, 64'h8000_1000, 64'h0, 64'h0, 0);
    tbl[8].e = mke(0, 0, 0,0, 0,0, 0,0, 64'h0);
    tbl[9]  = mkv(1,0,1,1,0, 64'h100, 64'h0, 64'h203, 64'h5555, 64'h88, 2);
    tbl[9].e = mke(1, 3, 12'h341,64'h100, 12'h342,64'd11, 12'h300,64'h1880, 64'h200);
    tbl[10] = mkv(1,1,0,0,0, 64'h40, 64'h0, 64'hffff_ffff_ffff_ffff, 64'h0,
                  64'hffff_0000_0000_0008, 0);
    tbl[10].e = mke(1, 3, 12'h341,64'h40, 12'h342,64'h8000_0000_0000_0007,
                    12'h300,64'hffff_0000_0000_1880, 64'hffff_ffff_ffff_fffc);

    for (int i = 0; i < 11; i++) run(tbl[i], $sformatf("tbl%0d", i));

    // Reset asserted while the mcause write is on the port.
    @(negedge clk);
    clear_inputs();
    commit_valid = 1; ecall = 1; commit_pc = 64'h8000_0060;
    csr_mtvec = 64'h8000_3000; csr_mstatus = 64'h8;
    #1 chk("mrst_stall_T", 64'(stall), 64'd1);
    @(negedge clk);
    junk();
    #1 chk("mrst_mepc_addr", 64'(csr_waddr), 64'h341);
    @(negedge clk);
    junk();
    #1 chk("mrst_mcause_addr", 64'(csr_waddr), 64'h342);
    commit_valid = 0;
    #1 rst_n = 1'b0;
    #1;
    chk_quiet("mrst_async");
    chk("mrst_async_stall", 64'(stall), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk("mrst_after_wen", 64'(csr_wen), 64'd0);
      chk("mrst_after_stall", 64'(stall), 64'd0);
    end

    // Randomized back-to-back transactions against the reference model.
    for (int n = 0; n < 60; n++) begin
      rv = mkv(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
               1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
               {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
               2'($urandom_range(0, 3)));
      rv.e = model(rv);
      run(rv, $sformatf("rnd%0d", n));
    end

    run(tbl[7], "final_idle");
    @(negedge clk);
    clear_inputs();
    #1 chk_quiet("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
